axis_stream_monitor: RTL and testbench
======================================

# axis_stream_monitor

Passive, parametrised AXI-Stream tap that observes one stream's handshake without driving or back-pressuring it. It extracts a configurable field from every accepted beat, keeps saturating beat/packet/stall statistics, and runs an arm/trigger capture of up to DEPTH consecutive fields into an on-chip buffer readable by a host. It sits beside any CORDIC/FFT/DSP stage in the radio pipeline, for bring-up and debug.

## Interface
Parameters:
- TDATA_W, 64, width of observed tdata
- FIELD_LSB, 32, lowest tdata bit of the extracted field
- FIELD_W, 32, extracted field width; FIELD_LSB+FIELD_W ≤ TDATA_W (elaboration error otherwise)
- DEPTH, 256, capture buffer entries; power of two, ≥2
- CNT_W, 32, statistics counter width

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  asynchronous, active-low reset
- mon_tvalid  in  1  observed tvalid
- mon_tready  in  1  observed tready
- mon_tlast  in  1  observed tlast
- mon_tdata  in  TDATA_W  observed tdata
- arm  in  1  pulse: start capture sequence
- abort  in  1  pulse: cancel capture, go IDLE
- sop_mode  in  1  1 = capture starts at first beat of a packet
- stop_on_eop  in  1  1 = capture ends at tlast beat
- clr_stats  in  1  pulse: clear counters and error flags
- rd_addr  in  $clog2(DEPTH)  buffer read address
- rd_data  out  FIELD_W  buffer contents at rd_addr
- snooped_field  out  FIELD_W  field of most recent accepted beat
- beat_cnt, pkt_cnt, stall_cnt  out  CNT_W  statistics
- cap_state  out  2  capture state encoding
- cap_len  out  $clog2(DEPTH)+1  entries captured
- proto_err  out  2  sticky protocol-error flags

## Operation
- Handshake hs = mon_tvalid & mon_tready. Stall = mon_tvalid & ~mon_tready. Block never drives the stream.
- On hs: snooped_field ← mon_tdata[FIELD_LSB +: FIELD_W]; beat_cnt++; pkt_cnt++ if mon_tlast. On stall: stall_cnt++. Counters saturate at all-ones.
- in_pkt flag: set on hs with ~tlast, cleared on hs with tlast. A beat is SOP when hs & ~in_pkt.
- Capture FSM: IDLE(0) → ARMED(1) on arm. ARMED → CAPTURE(2) on first qualifying beat (any hs if sop_mode=0, SOP hs if 1); that beat written at index 0. CAPTURE writes each hs at index cap_len, cap_len++. CAPTURE → DONE(3) when cap_len reaches DEPTH, or on hs with tlast when stop_on_eop=1 (that beat included). DONE → ARMED on arm (cap_len cleared). abort from any state → IDLE, cap_len kept, buffer contents kept.
- arm while ARMED/CAPTURE ignored. Simultaneous arm and abort: abort wins.
- clr_stats and an hs/stall in the same cycle: clear wins, event not counted. clr_stats does not affect the capture FSM.

## Timing
- All outputs registered. Reset: snooped_field 0, all counters 0, cap_state IDLE, cap_len 0, proto_err 0, in_pkt 0, rd_data 0; buffer contents undefined.
- hs in cycle N → snooped_field, counters, cap_len, cap_state visible in N+1.
- arm in cycle N → ARMED in N+1; a qualifying hs in cycle N itself is not captured.
- rd_data: one-cycle read latency from rd_addr; reading an address being written the same cycle returns old data.
- Reset assertion mid-capture returns to IDLE asynchronously.

## Configuration
- AXIS_MON_PROTO_CHK_EN defined: proto_err[0] sets when mon_tvalid&~mon_tready in cycle N and in N+1 mon_tvalid is high with tdata or tlast changed; proto_err[1] sets when that stall is followed by mon_tvalid low. Sticky until clr_stats or reset.
- Undefined: checker logic absent, proto_err tied to 0.

## Structure
- Package axis_mon_pkg: cap_state_t enum (IDLE, ARMED, CAPTURE, DONE), proto_err bit indices PERR_DATA_CHG=0, PERR_VALID_DROP=1.
- Sub-module axis_mon_capture_ram: simple dual-port RAM, DEPTH×FIELD_W, sync write, registered read.

## Test plan
- Defaults, 10 back-to-back beats, tdata[63:32]=i, tlast on beat 10 → beat_cnt=10, pkt_cnt=1, snooped_field=10.
- tvalid high, tready low 5 cycles then 1 hs → stall_cnt=5, beat_cnt=1.
- arm, sop_mode=1, stream starts mid-packet (3 beats then tlast), next packet 4 beats with stop_on_eop=1 → capture skips first packet, cap_len=4, DONE, rd_data[0..3] = second packet fields.
- DEPTH=4, arm, 6 beats, sop_mode=0, stop_on_eop=0 → DONE after 4, cap_len=4, beats 5–6 not stored; arm again → ARMED, cap_len=0.
- CNT_W=4, 20 beats → beat_cnt=15; clr_stats coincident with hs → beat_cnt=0 next cycle.
- With AXIS_MON_PROTO_CHK_EN: change tdata during stall → proto_err=2'b01; drop tvalid during stall → 2'b11; clr_stats → 0. Without the macro: same stimulus → proto_err stays 0.

Source files
------------

// File: rtl/axis_mon_pkg.sv
// Shared types and constants for the AXI-Stream monitor: capture state encoding
// and bit positions inside the sticky protocol-error vector.
package axis_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int PERR_DATA_CHG   = 0;
    localparam int PERR_VALID_DROP = 1;

endpackage

// File: rtl/axis_mon_capture_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read.
// A read of the address being written in the same cycle returns the previous contents.
module axis_mon_capture_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage has no reset so it maps onto plain RAM macros.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_stream_monitor.sv
// Passive AXI-Stream tap: field snoop, saturating statistics and arm/trigger capture.
// Optional handshake-rule checker is built in when AXIS_MON_PROTO_CHK_EN is defined.
// state   | meaning
// IDLE    | no capture in progress
// ARMED   | waiting for the first qualifying beat
// CAPTURE | storing every accepted beat
// DONE    | buffer frozen until re-armed
module axis_stream_monitor
    import axis_mon_pkg::*;
#(
    parameter int TDATA_W   = 64,
    parameter int FIELD_LSB = 32,
    parameter int FIELD_W   = 32,
    parameter int DEPTH     = 256,
    parameter int CNT_W     = 32
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_aresetn,
    input  logic                     mon_tvalid,
    input  logic                     mon_tready,
    input  logic                     mon_tlast,
    input  logic [TDATA_W-1:0]       mon_tdata,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     sop_mode,
    input  logic                     stop_on_eop,
    input  logic                     clr_stats,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [FIELD_W-1:0]       rd_data,
    output logic [FIELD_W-1:0]       snooped_field,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [1:0]               cap_state,
    output logic [$clog2(DEPTH):0]   cap_len,
    output logic [1:0]               proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (FIELD_LSB + FIELD_W > TDATA_W) begin : g_bad_field
        $error("axis_stream_monitor: FIELD_LSB+FIELD_W exceeds TDATA_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_stream_monitor: DEPTH must be a power of two >= 2");
    end

    logic               hs;
    logic               stall;
    logic [FIELD_W-1:0] field;
    logic               unused_tdata;

    assign hs           = mon_tvalid & mon_tready;
    assign stall        = mon_tvalid & ~mon_tready;
    assign field        = mon_tdata[FIELD_LSB +: FIELD_W];
    assign unused_tdata = ^mon_tdata;

    logic [FIELD_W-1:0] snoop_q;
    logic               in_pkt_q;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (clr_stats) begin
            beat_cnt_d  = '0;
            pkt_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (hs && beat_cnt_q != CNT_MAX) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
            if (hs && mon_tlast && pkt_cnt_q != CNT_MAX) begin
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end
            if (stall && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            snoop_q     <= '0;
            in_pkt_q    <= 1'b0;
            beat_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            if (hs) begin
                snoop_q  <= field;
                in_pkt_q <= ~mon_tlast;
            end
        end
    end

    cap_state_t  cap_state_q;
    logic [AW:0] cap_len_q;
    logic [AW:0] cap_len_nxt;
    logic        qualify;
    logic        cap_end;
    logic        cap_wr;

    // ARMED always holds cap_len at zero, so the write index is cap_len in both capturing states.
    assign qualify     = hs & (~sop_mode | ~in_pkt_q);
    assign cap_len_nxt = cap_len_q + (AW + 1)'(1);
    assign cap_end     = (cap_len_nxt == DEPTH_L) | (stop_on_eop & mon_tlast);
    assign cap_wr      = ~abort & (((cap_state_q == ARMED) & qualify) |
                                   ((cap_state_q == CAPTURE) & hs));

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            cap_state_q <= IDLE;
            cap_len_q   <= '0;
        end else if (abort) begin
            cap_state_q <= IDLE;
        end else begin
            case (cap_state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        cap_state_q <= ARMED;
                        cap_len_q   <= '0;
                    end
                end
                ARMED: begin
                    if (qualify) begin
                        cap_len_q   <= cap_len_nxt;
                        cap_state_q <= cap_end ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (hs) begin
                        cap_len_q <= cap_len_nxt;
                        if (cap_end) begin
                            cap_state_q <= DONE;
                        end
                    end
                end
                default: cap_state_q <= IDLE;
            endcase
        end
    end

    axis_mon_capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FIELD_W)
    ) u_ram (
        .clk_i     (s00_axis_aclk),
        .rst_n_i   (s00_axis_aresetn),
        .wr_en_i   (cap_wr),
        .wr_addr_i (cap_len_q[AW-1:0]),
        .wr_data_i (field),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

`ifdef AXIS_MON_PROTO_CHK_EN
    logic               prev_stall_q;
    logic               prev_tlast_q;
    logic [TDATA_W-1:0] prev_tdata_q;
    logic [1:0]         perr_q;

    // A stalled beat must be held unchanged and kept valid until it is accepted.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            prev_stall_q <= 1'b0;
            prev_tlast_q <= 1'b0;
            prev_tdata_q <= '0;
            perr_q       <= '0;
        end else begin
            prev_stall_q <= stall;
            prev_tlast_q <= mon_tlast;
            prev_tdata_q <= mon_tdata;
            if (clr_stats) begin
                perr_q <= '0;
            end else if (prev_stall_q) begin
                if (mon_tvalid && (mon_tdata != prev_tdata_q || mon_tlast != prev_tlast_q)) begin
                    perr_q[PERR_DATA_CHG] <= 1'b1;
                end
                if (!mon_tvalid) begin
                    perr_q[PERR_VALID_DROP] <= 1'b1;
                end
            end
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 2'b00;
`endif

    assign snooped_field = snoop_q;
    assign beat_cnt      = beat_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign stall_cnt     = stall_cnt_q;
    assign cap_state     = cap_state_q;
    assign cap_len       = cap_len_q;

endmodule

// File: tb/tb_axis_stream_monitor.sv
// Self-checking bench: a default-size monitor and a DEPTH=4/CNT_W=4 monitor watch the same stream.
module tb_axis_stream_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
    logic [63:0] tdata = '0;
    logic        arm = 1'b0, abort = 1'b0, sop_mode = 1'b0, stop_on_eop = 1'b0, clr = 1'b0;
    logic [7:0]  rd_addr = '0;

    logic [31:0] o_rd [2];
    logic [31:0] o_sn [2];
    logic [31:0] o_bc [2];
    logic [31:0] o_pc [2];
    logic [31:0] o_sc [2];
    logic [1:0]  o_cs [2];
    logic [1:0]  o_pe [2];
    logic [8:0]  o_cl [2];

    logic [3:0]  bc1, pc1, sc1;
    logic [2:0]  cl1;

    axis_stream_monitor u_dut0 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tlast(tlast), .mon_tdata(tdata),
        .arm(arm), .abort(abort), .sop_mode(sop_mode), .stop_on_eop(stop_on_eop),
        .clr_stats(clr), .rd_addr(rd_addr), .rd_data(o_rd[0]), .snooped_field(o_sn[0]),
        .beat_cnt(o_bc[0]), .pkt_cnt(o_pc[0]), .stall_cnt(o_sc[0]),
        .cap_state(o_cs[0]), .cap_len(o_cl[0]), .proto_err(o_pe[0])
    );

    axis_stream_monitor #(.DEPTH(4), .CNT_W(4)) u_dut1 (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tlast(tlast), .mon_tdata(tdata),
        .arm(arm), .abort(abort), .sop_mode(sop_mode), .stop_on_eop(stop_on_eop),
        .clr_stats(clr), .rd_addr(rd_addr[1:0]), .rd_data(o_rd[1]), .snooped_field(o_sn[1]),
        .beat_cnt(bc1), .pkt_cnt(pc1), .stall_cnt(sc1),
        .cap_state(o_cs[1]), .cap_len(cl1), .proto_err(o_pe[1])
    );

    assign o_bc[1] = {28'd0, bc1};
    assign o_pc[1] = {28'd0, pc1};
    assign o_sc[1] = {28'd0, sc1};
    assign o_cl[1] = {6'd0, cl1};

`ifdef AXIS_MON_PROTO_CHK_EN
    localparam logic [1:0] PE_DATA = 2'b01;
    localparam logic [1:0] PE_BOTH = 2'b11;
`else
    localparam logic [1:0] PE_DATA = 2'b00;
    localparam logic [1:0] PE_BOTH = 2'b00;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: statistics as plain integers, capture as a list of stored fields.
    longint      cmax [2] = '{64'hFFFF_FFFF, 64'd15};
    int          m_depth [2] = '{256, 4};
    longint      m_beat [2], m_pkt [2], m_stall [2];
    int          m_state [2], m_len [2];
    logic [31:0] m_snoop [2];
    logic [31:0] m_mem [2][256];
    bit          m_wr [2][256];
    logic [31:0] m_rd [2];
    bit          m_rdv [2];
    bit          m_inpkt;
    logic [1:0]  m_perr;
    bit          p_stall;
    logic [63:0] p_data;
    logic        p_last;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_beat[k] = 0; m_pkt[k] = 0; m_stall[k] = 0;
            m_state[k] = 0; m_len[k] = 0; m_snoop[k] = '0;
            m_rdv[k] = 0; m_rd[k] = '0;
            for (int a = 0; a < 256; a++) m_wr[k][a] = 0;
        end
        m_inpkt = 0; m_perr = '0; p_stall = 0; p_data = '0; p_last = 1'b0;
    endtask

    task automatic model_step();
        bit          hs, st, qual;
        int          a;
        logic [31:0] fld;
        hs  = tvalid && tready;
        st  = tvalid && !tready;
        fld = tdata[63:32];
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? int'(rd_addr) : int'(rd_addr[1:0]);
            m_rdv[k] = m_wr[k][a];
            m_rd[k]  = m_mem[k][a];
            if (clr) begin
                m_beat[k] = 0; m_pkt[k] = 0; m_stall[k] = 0;
            end else begin
                if (hs && m_beat[k] < cmax[k]) m_beat[k]++;
                if (hs && tlast && m_pkt[k] < cmax[k]) m_pkt[k]++;
                if (st && m_stall[k] < cmax[k]) m_stall[k]++;
            end
            if (hs) m_snoop[k] = fld;
            qual = hs && (!sop_mode || !m_inpkt);
            if (abort) m_state[k] = 0;
            else if ((m_state[k] == 0 || m_state[k] == 3) && arm) begin
                m_state[k] = 1; m_len[k] = 0;
            end else if ((m_state[k] == 1 && qual) || (m_state[k] == 2 && hs)) begin
                m_mem[k][m_len[k]] = fld;
                m_wr[k][m_len[k]]  = 1;
                m_len[k]++;
                m_state[k] = (m_len[k] == m_depth[k] || (stop_on_eop && tlast)) ? 3 : 2;
            end
        end
        if (clr) m_perr = '0;
        else begin
            if (p_stall && tvalid && (tdata !== p_data || tlast !== p_last)) m_perr[0] = 1'b1;
            if (p_stall && !tvalid) m_perr[1] = 1'b1;
        end
        p_stall = st; p_data = tdata; p_last = tlast;
        if (hs) m_inpkt = !tlast;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
        arm = 1'b0; abort = 1'b0; clr = 1'b0;
    endtask

    task automatic beat(input logic [31:0] f, input logic last);
        tvalid = 1'b1; tready = 1'b1; tlast = last;
        tdata = {f, 32'($urandom)};
        tick();
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_bc[k] !== 0) begin n_err++; $display("FAIL reset_beat[%0d] got %0d want 0", k, o_bc[k]); end
            n_cmp++; if (o_pc[k] !== 0) begin n_err++; $display("FAIL reset_pkt[%0d] got %0d want 0", k, o_pc[k]); end
            n_cmp++; if (o_sc[k] !== 0) begin n_err++; $display("FAIL reset_stall[%0d] got %0d want 0", k, o_sc[k]); end
            n_cmp++; if (o_sn[k] !== 0) begin n_err++; $display("FAIL reset_snoop[%0d] got %h want 0", k, o_sn[k]); end
            n_cmp++; if (o_cs[k] !== 0) begin n_err++; $display("FAIL reset_state[%0d] got %0d want 0", k, o_cs[k]); end
            n_cmp++; if (o_cl[k] !== 0) begin n_err++; $display("FAIL reset_len[%0d] got %0d want 0", k, o_cl[k]); end
            n_cmp++; if (o_pe[k] !== 0) begin n_err++; $display("FAIL reset_perr[%0d] got %b want 0", k, o_pe[k]); end
            n_cmp++; if (o_rd[k] !== 0) begin n_err++; $display("FAIL reset_rd[%0d] got %h want 0", k, o_rd[k]); end
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_burst();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tvalid = 1'b1; tready = 1'b1; tlast = (i == 10);
            tdata = {32'(i), 32'($urandom)};
            tick();
        end
        idle_bus();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_bc[k] !== 10) begin n_err++; $display("FAIL burst_beat[%0d] got %0d want 10", k, o_bc[k]); end
            n_cmp++; if (o_pc[k] !== 1) begin n_err++; $display("FAIL burst_pkt[%0d] got %0d want 1", k, o_pc[k]); end
            n_cmp++; if (o_sn[k] !== 10) begin n_err++; $display("FAIL burst_snoop[%0d] got %0d want 10", k, o_sn[k]); end
        end
    endtask

    task automatic test_stall();
        clr = 1'b1; tick(); clr = 1'b0;
        tvalid = 1'b1; tready = 1'b0; tdata = 64'h1234_5678_9ABC_DEF0;
        repeat (5) tick();
        tready = 1'b1;
        tick();
        idle_bus();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_sc[k] !== 5) begin n_err++; $display("FAIL stall_cnt[%0d] got %0d want 5", k, o_sc[k]); end
            n_cmp++; if (o_bc[k] !== 1) begin n_err++; $display("FAIL stall_beat[%0d] got %0d want 1", k, o_bc[k]); end
        end
    endtask

    task automatic test_sop_capture();
        sop_mode = 1'b1; stop_on_eop = 1'b1;
        abort = 1'b1; tick(); abort = 1'b0;
        beat(32'hA0, 1'b0);
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 1; i <= 3; i++) beat(32'hB0 + 32'(i), i == 3);
        for (int i = 1; i <= 4; i++) beat(32'hC0 + 32'(i), i == 4);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_cs[k] !== 3) begin n_err++; $display("FAIL sop_state[%0d] got %0d want 3", k, o_cs[k]); end
            n_cmp++; if (o_cl[k] !== 4) begin n_err++; $display("FAIL sop_len[%0d] got %0d want 4", k, o_cl[k]); end
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 8'(a); tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_rd[k] !== 32'hC1 + 32'(a)) begin
                    n_err++; $display("FAIL sop_rd[%0d][%0d] got %h want %h", k, a, o_rd[k], 32'hC1 + 32'(a));
                end
            end
        end
    endtask

    task automatic test_depth_limit();
        sop_mode = 1'b0; stop_on_eop = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        arm = 1'b1; beat(32'd100, 1'b0); arm = 1'b0;
        for (int i = 1; i <= 6; i++) beat(32'(i), 1'b0);
        n_cmp++; if (o_cs[1] !== 3) begin n_err++; $display("FAIL depth_state_small got %0d want 3", o_cs[1]); end
        n_cmp++; if (o_cl[1] !== 4) begin n_err++; $display("FAIL depth_len_small got %0d want 4", o_cl[1]); end
        n_cmp++; if (o_cs[0] !== 2) begin n_err++; $display("FAIL depth_state_big got %0d want 2", o_cs[0]); end
        n_cmp++; if (o_cl[0] !== 6) begin n_err++; $display("FAIL depth_len_big got %0d want 6", o_cl[0]); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 8'(a); tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_rd[k] !== 32'(a + 1)) begin
                    n_err++; $display("FAIL depth_rd[%0d][%0d] got %h want %h", k, a, o_rd[k], a + 1);
                end
            end
        end
        arm = 1'b1; tick(); arm = 1'b0;
        n_cmp++; if (o_cs[1] !== 1) begin n_err++; $display("FAIL rearm_state_small got %0d want 1", o_cs[1]); end
        n_cmp++; if (o_cl[1] !== 0) begin n_err++; $display("FAIL rearm_len_small got %0d want 0", o_cl[1]); end
        n_cmp++; if (o_cs[0] !== 2) begin n_err++; $display("FAIL arm_ignored_state got %0d want 2", o_cs[0]); end
        n_cmp++; if (o_cl[0] !== 6) begin n_err++; $display("FAIL arm_ignored_len got %0d want 6", o_cl[0]); end
        abort = 1'b1; tick(); abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_cs[k] !== 0) begin n_err++; $display("FAIL abort_state[%0d] got %0d want 0", k, o_cs[k]); end
        end
    endtask

    task automatic test_saturate();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 20; i++) beat(32'(i), 1'b0);
        n_cmp++; if (o_bc[1] !== 15) begin n_err++; $display("FAIL sat_beat_small got %0d want 15", o_bc[1]); end
        n_cmp++; if (o_bc[0] !== 20) begin n_err++; $display("FAIL sat_beat_big got %0d want 20", o_bc[0]); end
        clr = 1'b1; beat(32'h55, 1'b1); clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_bc[k] !== 0) begin n_err++; $display("FAIL clr_wins_beat[%0d] got %0d want 0", k, o_bc[k]); end
            n_cmp++; if (o_pc[k] !== 0) begin n_err++; $display("FAIL clr_wins_pkt[%0d] got %0d want 0", k, o_pc[k]); end
        end
    endtask

    task automatic test_proto();
        clr = 1'b1; tick(); clr = 1'b0;
        tvalid = 1'b1; tready = 1'b0; tdata = 64'h1111_2222_3333_4444; tick();
        tdata = 64'h5555_6666_7777_8888; tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_pe[k] !== PE_DATA) begin n_err++; $display("FAIL perr_data[%0d] got %b want %b", k, o_pe[k], PE_DATA); end
        end
        tvalid = 1'b0; tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_pe[k] !== PE_BOTH) begin n_err++; $display("FAIL perr_drop[%0d] got %b want %b", k, o_pe[k], PE_BOTH); end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_pe[k] !== 2'b00) begin n_err++; $display("FAIL perr_clr[%0d] got %b want 00", k, o_pe[k]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] exp_pe;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                sop_mode = 1'($urandom); stop_on_eop = 1'($urandom);
            end
            tvalid  = ($urandom % 4) != 0;
            tready  = ($urandom % 3) != 0;
            tlast   = ($urandom % 5) == 0;
            if (($urandom % 4) != 0 || !p_stall) tdata = {$urandom, $urandom};
            arm     = ($urandom % 20) == 0;
            abort   = ($urandom % 97) == 0;
            clr     = ($urandom % 150) == 0;
            rd_addr = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom % 8);
            tick();
`ifdef AXIS_MON_PROTO_CHK_EN
            exp_pe = m_perr;
`else
            exp_pe = 2'b00;
`endif
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (o_bc[k] !== 32'(m_beat[k])) begin n_err++; $display("FAIL rnd_beat[%0d] cyc %0d got %0d want %0d", k, c, o_bc[k], m_beat[k]); end
                n_cmp++; if (o_pc[k] !== 32'(m_pkt[k])) begin n_err++; $display("FAIL rnd_pkt[%0d] cyc %0d got %0d want %0d", k, c, o_pc[k], m_pkt[k]); end
                n_cmp++; if (o_sc[k] !== 32'(m_stall[k])) begin n_err++; $display("FAIL rnd_stall[%0d] cyc %0d got %0d want %0d", k, c, o_sc[k], m_stall[k]); end
                n_cmp++; if (o_sn[k] !== m_snoop[k]) begin n_err++; $display("FAIL rnd_snoop[%0d] cyc %0d got %h want %h", k, c, o_sn[k], m_snoop[k]); end
                n_cmp++; if (o_cs[k] !== 2'(m_state[k])) begin n_err++; $display("FAIL rnd_state[%0d] cyc %0d got %0d want %0d", k, c, o_cs[k], m_state[k]); end
                n_cmp++; if (o_cl[k] !== 9'(m_len[k])) begin n_err++; $display("FAIL rnd_len[%0d] cyc %0d got %0d want %0d", k, c, o_cl[k], m_len[k]); end
                n_cmp++; if (o_pe[k] !== exp_pe) begin n_err++; $display("FAIL rnd_perr[%0d] cyc %0d got %b want %b", k, c, o_pe[k], exp_pe); end
                if (m_rdv[k]) begin
                    n_cmp++; if (o_rd[k] !== m_rd[k]) begin n_err++; $display("FAIL rnd_rd[%0d] cyc %0d got %h want %h", k, c, o_rd[k], m_rd[k]); end
                end
            end
        end
        idle_bus();
    endtask

    task automatic test_async_reset();
        sop_mode = 1'b0; stop_on_eop = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        beat(32'hFACE, 1'b0);
        n_cmp++; if (o_cs[0] !== 2) begin n_err++; $display("FAIL pre_rst_state got %0d want 2", o_cs[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (o_cs[k] !== 0) begin n_err++; $display("FAIL async_rst_state[%0d] got %0d want 0", k, o_cs[k]); end
            n_cmp++; if (o_cl[k] !== 0) begin n_err++; $display("FAIL async_rst_len[%0d] got %0d want 0", k, o_cl[k]); end
            n_cmp++; if (o_bc[k] !== 0) begin n_err++; $display("FAIL async_rst_beat[%0d] got %0d want 0", k, o_bc[k]); end
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_burst();
        test_stall();
        test_sop_capture();
        test_depth_limit();
        test_saturate();
        test_proto();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
